// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths, default parameters and the buffered-result entry type for the
// writeback arbiter.
package wb_write_arbiter_pkg;

  localparam int REGNOBITS               = 5;
  localparam int DBITS                   = 32;
  localparam int LU_FIFO_DEPTH           = 2;
  localparam int LU_STARVE_LIMIT         = 4;
  localparam int WAIT_BITS               = 4;
  localparam int from_WB_ARB_to_DE_WIDTH = 1 + REGNOBITS + DBITS;

  typedef struct packed {
    logic [REGNOBITS-1:0] wregno;
    logic [DBITS-1:0]     regval;
  } lu_entry_t;

  function automatic logic [WAIT_BITS-1:0] sat_inc(input logic [WAIT_BITS-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between WB/long-latency unit (master side) and the arbiter (slave side).
interface wb_write_arbiter_if import wb_write_arbiter_pkg::*; #(
  parameter int DEPTH = LU_FIFO_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 pipe_wr_reg;
  logic [REGNOBITS-1:0] pipe_wregno;
  logic [DBITS-1:0]     pipe_regval;
  logic                 lu_valid;
  logic                 lu_ready;
  logic [REGNOBITS-1:0] lu_wregno;
  logic [DBITS-1:0]     lu_regval;
  logic                 wr_reg_out;
  logic [REGNOBITS-1:0] wregno_out;
  logic [DBITS-1:0]     regval_out;
  logic [CW-1:0]        lu_count;
  logic                 stall_req;
  logic                 waw_err;

  modport master (
    output pipe_wr_reg, pipe_wregno, pipe_regval, lu_valid, lu_wregno, lu_regval,
    input  lu_ready, wr_reg_out, wregno_out, regval_out, lu_count, stall_req, waw_err
  );

  modport slave (
    input  pipe_wr_reg, pipe_wregno, pipe_regval, lu_valid, lu_wregno, lu_regval,
    output lu_ready, wr_reg_out, wregno_out, regval_out, lu_count, stall_req, waw_err
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results; exposes every slot and a
// per-slot valid mask so the arbiter can scan for WAW hazards.
module wb_result_fifo import wb_write_arbiter_pkg::*; #(
  parameter int DEPTH = LU_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  lu_entry_t              din,
  output lu_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output lu_entry_t [DEPTH-1:0]  slots,
  output logic [DEPTH-1:0]       valid
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      slots  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++)
      valid[i] = {1'b0, AW'(i) - rd_ptr} < count;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port between the WB pipeline (always wins) and
// buffered long-latency results drained into idle slots.
module wb_write_arbiter import wb_write_arbiter_pkg::*; #(
  parameter int DEPTH        = LU_FIFO_DEPTH,
  parameter int STARVE_LIMIT = LU_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  wb_write_arbiter_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  pipe_we;
  logic                  fifo_empty;
  logic                  do_pop;
  logic                  accept;
  logic                  do_push;
  logic                  waw_hit;
  logic [CW-1:0]         count;
  logic [WAIT_BITS-1:0]  wait_cnt;
  logic                  waw_q;
  lu_entry_t             din;
  lu_entry_t             head;
  lu_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0]      valid;

  assign pipe_we    = bus.pipe_wr_reg && (bus.pipe_wregno != '0);
  assign fifo_empty = (count == '0);
  assign do_pop     = !pipe_we && !fifo_empty;

  assign bus.lu_ready = (count < CW'(DEPTH));
  assign accept       = bus.lu_valid && bus.lu_ready;
  assign do_push      = accept && (bus.lu_wregno != '0);
  assign din          = '{wregno: bus.lu_wregno, regval: bus.lu_regval};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (din),
    .head  (head),
    .count (count),
    .slots (slots),
    .valid (valid)
  );

  always_comb begin
    bus.wr_reg_out = 1'b0;
    bus.wregno_out = '0;
    bus.regval_out = '0;
    if (pipe_we) begin
      bus.wr_reg_out = 1'b1;
      bus.wregno_out = bus.pipe_wregno;
      bus.regval_out = bus.pipe_regval;
    end else if (!fifo_empty) begin
      bus.wr_reg_out = 1'b1;
      bus.wregno_out = head.wregno;
      bus.regval_out = head.regval;
    end
  end

  // Hazard: pipeline writes a register that still has an older result in flight.
  always_comb begin
    waw_hit = do_push && (bus.lu_wregno == bus.pipe_wregno);
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && (slots[i].wregno == bus.pipe_wregno))
        waw_hit = 1'b1;
    waw_hit = waw_hit && pipe_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      waw_q    <= 1'b0;
    end else begin
      if (fifo_empty || do_pop)
        wait_cnt <= '0;
      else if (pipe_we)
        wait_cnt <= sat_inc(wait_cnt);
      if (waw_hit)
        waw_q <= 1'b1;
    end
  end

  assign bus.stall_req = (wait_cnt >= WAIT_BITS'(STARVE_LIMIT));
  assign bus.waw_err   = waw_q;
  assign bus.lu_count  = count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: inputs change on negedge, outputs are
// checked 2 ns later, well before the next posedge.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  wb_write_arbiter_if #(.DEPTH(2)) bus ();

  wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] pno, input logic [31:0] pval,
                       input logic lv, input logic [4:0] lno, input logic [31:0] lval);
    @(negedge clk);
    bus.pipe_wr_reg = pw;
    bus.pipe_wregno = pno;
    bus.pipe_regval = pval;
    bus.lu_valid    = lv;
    bus.lu_wregno   = lno;
    bus.lu_regval   = lval;
    #2;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] no, input logic [31:0] val);
    chk({tag, "_we"}, {31'd0, bus.wr_reg_out}, {31'd0, we});
    chk({tag, "_no"}, {27'd0, bus.wregno_out}, {27'd0, no});
    chk({tag, "_val"}, bus.regval_out, val);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.pipe_wr_reg = 1'b0;
    bus.pipe_wregno = '0;
    bus.pipe_regval = '0;
    bus.lu_valid    = 1'b0;
    bus.lu_wregno   = '0;
    bus.lu_regval   = '0;
    #2;
    chk("rst_count", {30'd0, bus.lu_count}, 32'd0);
    chk("rst_ready", {31'd0, bus.lu_ready}, 32'd1);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("rst_waw",   {31'd0, bus.waw_err}, 32'd0);
    chk_out("rst_out", 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // pipe-only passthrough, and x0 pipeline write is suppressed
    drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0);
    chk_out("pipe", 1'b1, 5'd5, 32'h1234);
    drive(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0);
    chk_out("pipe_x0", 1'b0, 5'd0, 32'h0);
    chk("pipe_count", {30'd0, bus.lu_count}, 32'd0);

    // idle drain: accepted result never bypasses, written next cycle
    drive(0, 5'd0, 32'h0, 1, 5'd7, 32'hBEEF);
    chk("drain_ready", {31'd0, bus.lu_ready}, 32'd1);
    chk_out("drain_nobyp", 1'b0, 5'd0, 32'h0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("drain_count1", {30'd0, bus.lu_count}, 32'd1);
    chk_out("drain_wr", 1'b1, 5'd7, 32'hBEEF);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("drain_count0", {30'd0, bus.lu_count}, 32'd0);
    chk_out("drain_idle", 1'b0, 5'd0, 32'h0);

    // full / backpressure
    drive(1, 5'd10, 32'hA, 1, 5'd1, 32'h11);
    chk("full_c0_ready", {31'd0, bus.lu_ready}, 32'd1);
    drive(1, 5'd11, 32'hB, 1, 5'd2, 32'h22);
    chk("full_c1_count", {30'd0, bus.lu_count}, 32'd1);
    chk_out("full_c1_pipe", 1'b1, 5'd11, 32'hB);
    drive(1, 5'd12, 32'hC, 1, 5'd3, 32'h33);
    chk("full_c2_count", {30'd0, bus.lu_count}, 32'd2);
    chk("full_c2_ready", {31'd0, bus.lu_ready}, 32'd0);
    drive(1, 5'd12, 32'hC, 1, 5'd3, 32'h33);
    chk("full_c3_count", {30'd0, bus.lu_count}, 32'd2);
    drive(0, 5'd0, 32'h0, 1, 5'd3, 32'h33);
    chk("full_c4_ready", {31'd0, bus.lu_ready}, 32'd0);
    chk_out("full_c4_x1", 1'b1, 5'd1, 32'h11);
    chk("full_c4_stall", {31'd0, bus.stall_req}, 32'd0);
    drive(0, 5'd0, 32'h0, 1, 5'd3, 32'h33);
    chk("full_c5_ready", {31'd0, bus.lu_ready}, 32'd1);
    chk("full_c5_count", {30'd0, bus.lu_count}, 32'd1);
    chk_out("full_c5_x2", 1'b1, 5'd2, 32'h22);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("full_c6_count", {30'd0, bus.lu_count}, 32'd1);
    chk_out("full_c6_x3", 1'b1, 5'd3, 32'h33);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("full_c7_count", {30'd0, bus.lu_count}, 32'd0);

    // starvation: four blocked cycles -> stall in the fifth
    drive(0, 5'd0, 32'h0, 1, 5'd4, 32'h44);
    drive(1, 5'd13, 32'hD, 0, 5'd0, 32'h0);
    chk("starve_s1_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("starve_s1_count", {30'd0, bus.lu_count}, 32'd1);
    drive(1, 5'd14, 32'hE, 0, 5'd0, 32'h0);
    drive(1, 5'd15, 32'hF, 0, 5'd0, 32'h0);
    drive(1, 5'd16, 32'h10, 0, 5'd0, 32'h0);
    chk("starve_s4_stall", {31'd0, bus.stall_req}, 32'd0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("starve_s5_stall", {31'd0, bus.stall_req}, 32'd1);
    chk_out("starve_s5_x4", 1'b1, 5'd4, 32'h44);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("starve_s6_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("starve_s6_count", {30'd0, bus.lu_count}, 32'd0);

    // x0 long-latency result is consumed without a push
    drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h55);
    chk("x0_ready", {31'd0, bus.lu_ready}, 32'd1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("x0_count", {30'd0, bus.lu_count}, 32'd0);
    chk_out("x0_out", 1'b0, 5'd0, 32'h0);

    // WAW against a buffered entry
    drive(1, 5'd20, 32'h20, 1, 5'd9, 32'h99);
    chk("waw_w0", {31'd0, bus.waw_err}, 32'd0);
    drive(1, 5'd9, 32'h999, 0, 5'd0, 32'h0);
    chk("waw_w1", {31'd0, bus.waw_err}, 32'd0);
    chk_out("waw_w1_pipe", 1'b1, 5'd9, 32'h999);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("waw_w2", {31'd0, bus.waw_err}, 32'd1);
    chk_out("waw_w2_drain", 1'b1, 5'd9, 32'h99);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("waw_w3_hold", {31'd0, bus.waw_err}, 32'd1);

    // async reset mid-stream with an entry buffered
    drive(1, 5'd22, 32'h222, 1, 5'd23, 32'h233);
    drive(1, 5'd22, 32'h222, 0, 5'd0, 32'h0);
    chk("mid_count", {30'd0, bus.lu_count}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", {30'd0, bus.lu_count}, 32'd0);
    chk("mid_rst_waw",   {31'd0, bus.waw_err}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.lu_ready}, 32'd1);
    chk_out("mid_rst_pipe", 1'b1, 5'd22, 32'h222);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk_out("mid_nodrain", 1'b0, 5'd0, 32'h0);

    // WAW against a result accepted in the same cycle
    drive(1, 5'd24, 32'h24, 1, 5'd24, 32'h2424);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("waw_accept", {31'd0, bus.waw_err}, 32'd1);
    chk_out("waw_accept_drain", 1'b1, 5'd24, 32'h2424);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the single register-file write port between the in-order pipeline writeback path and a long-latency unit (e.g. MUL/DIV) that completes out of band. It sits between the WB stage and the DE-stage register file and produces the write bundle DE consumes (`wr_reg`, `wregno`, `regval`). The pipeline always has priority and is never back-pressured. Long-latency results are buffered in a small FIFO and drained into idle write slots; a starvation counter requests a front-end stall when draining falls behind.

## Interface
Parameters:
- `DEPTH`, 2: long-latency result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: cycles the FIFO head may wait before `stall_req` asserts (1..15).

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pipe_wr_reg`  in  1  WB stage requests a register write this cycle.
- `pipe_wregno`  in  `REGNOBITS` (5)  WB destination register.
- `pipe_regval`  in  `DBITS` (32)  WB write data.
- `lu_valid`  in  1  long-latency unit offers a result.
- `lu_ready`  out  1  arbiter accepts the offered result this cycle.
- `lu_wregno`  in  5  long-latency destination register.
- `lu_regval`  in  32  long-latency result.
- `wr_reg_out`  out  1  register-file write enable to DE.
- `wregno_out`  out  5  register-file write index.
- `regval_out`  out  32  register-file write data.
- `lu_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `stall_req`  out  1  request to freeze FE/DE so a write slot frees up.
- `waw_err`  out  1  sticky WAW-ordering violation flag.

## Operation
- Effective pipeline write: `pipe_we = pipe_wr_reg && pipe_wregno != 0`.
- Port mux, combinational. If `pipe_we`, the outputs carry the pipeline bundle. Otherwise, if the FIFO is non-empty, they carry the FIFO head and the head pops at the next posedge. Otherwise `wr_reg_out = 0` and index/data are 0.
- Accept: `lu_ready = (lu_count < DEPTH)`, a function of registered state only. A handshake (`lu_valid && lu_ready`) pushes `{lu_wregno, lu_regval}` at posedge.
  - An accepted result with `lu_wregno == 0` is consumed and discarded; no push.
- No bypass: an accepted result is never written in its accept cycle.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved (FIFO order = accept order).
- Starvation counter `wait_cnt` (4 bits):
  - Clears when the FIFO is empty or a pop occurs.
  - Otherwise increments when the head is blocked by `pipe_we`, saturating at 15.
  - `stall_req = (wait_cnt >= STARVE_LIMIT)`, registered-state only.
- WAW check: `waw_err` sets at posedge when `pipe_we` and `pipe_wregno` matches either any valid FIFO entry or a result being accepted that cycle with nonzero index. It stays set until reset. Data is still written as muxed; DE's scoreboard owns prevention.

## Timing
- Reset values: FIFO empty, `lu_count = 0`, `lu_ready = 1`, `wait_cnt = 0`, `stall_req = 0`, `waw_err = 0`.
  - `wr_reg_out`, `wregno_out`, `regval_out` follow the pipeline inputs (FIFO empty).
- Reset mid-operation discards all buffered results with no partial drain.
- Pipeline path latency is 0 (combinational passthrough), so DE forwarding timing is unchanged.
- Long-latency path minimum latency: accepted at posedge N, written in cycle N+1 if `pipe_we` is low in that cycle.
- Full: `lu_ready = 0` for the whole cycle, even if a pop occurs in that cycle. It reasserts the cycle after the pop.
- `stall_req` deasserts the cycle after the blocked head pops.

## Structure
- Add `LU_FIFO_DEPTH` and `STARVE_LIMIT` defaults to `define.vh` next to `REGNOBITS`/`DBITS`.
- Add `from_WB_ARB_to_DE_WIDTH` (= 1+5+32) to `define.vh`; DE unpacks it exactly as it unpacks the current WB bundle.
- One sub-module: `wb_result_fifo`, a parameterized synchronous FIFO with push/pop/count/head, async active-high reset, and registered pointers.
- The arbiter holds the mux, the starvation counter and the WAW check.

## Test plan
- Pipe-only: `pipe_wr_reg = 1`, x5 = 0x1234, `lu_valid = 0` → same-cycle `wr_reg_out = 1`, `wregno_out = 5`, `regval_out = 0x1234`; `lu_count` stays 0.
- Idle drain: accept x7 = 0xBEEF with pipe idle → write of x7/0xBEEF in the next cycle, then `lu_count` returns to 0.
- Full/backpressure: DEPTH = 2; accept x1, x2 while the pipe writes every cycle → `lu_ready = 0`, `lu_valid` held with x3 is not accepted. Drop `pipe_wr_reg` → x1 then x2 written in order, x3 accepted the cycle after the first pop.
- Starvation: one entry buffered, pipe writes 4 consecutive cycles → `stall_req = 1` in cycle 5. Pipe idle → entry written, `stall_req = 0` the following cycle.
- x0 and WAW: accept `lu_wregno = 0` → no push. Buffer x9, then the pipe writes x9 → `waw_err = 1` and it holds. Async `reset` mid-stream → all outputs at reset values immediately, FIFO empty.
